// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the robot-side UART command wrapper.
package uart_cmd_pkg;

    typedef enum logic {
        RX_IDLE,
        RX_WAIT_LOW
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_LOAD,
        TX_BUSY
    } tx_state_t;

    localparam logic [7:0] RESP_ACK = 8'hA5;
    localparam logic [7:0] RESP_NAK = 8'h5A;

endpackage

// File: rtl/uart_cmd_wrapper_if.sv
// Byte-level UART, command and response signals between the wrapper and its neighbours.
interface uart_cmd_wrapper_if;

    logic        rx_rdy;
    logic [7:0]  rx_data;
    logic        clr_rx_rdy;
    logic        trmt;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic [7:0]  resp;
    logic        send_resp;
    logic        resp_sent;
    logic        tx_busy;
    logic        frame_err;

    // Wrapper side
    modport slave (
        input  rx_rdy, rx_data, tx_done, clr_cmd_rdy, resp, send_resp,
        output clr_rx_rdy, trmt, tx_data, cmd, cmd_rdy, resp_sent, tx_busy, frame_err
    );

    // UART / command processor side
    modport master (
        output rx_rdy, rx_data, tx_done, clr_cmd_rdy, resp, send_resp,
        input  clr_rx_rdy, trmt, tx_data, cmd, cmd_rdy, resp_sent, tx_busy, frame_err
    );

endinterface

// File: rtl/uart_cmd_gap_timer.sv
// Inter-byte gap timer: restarts on start, counts while run, flags the last allowed cycle.
module uart_cmd_gap_timer #(
    parameter int unsigned GAP_TIMEOUT = 1_000_000,
    parameter int unsigned GAP_CNT_W   = (GAP_TIMEOUT > 0) ? $clog2(GAP_TIMEOUT + 1) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic run,
    output logic expired
);

    generate
        if (GAP_TIMEOUT == 0) begin : g_off
            assign expired = 1'b0;
        end else begin : g_on
            localparam logic [GAP_CNT_W-1:0] LAST = GAP_CNT_W'(GAP_TIMEOUT - 1);
            localparam logic [GAP_CNT_W-1:0] SAT  = GAP_CNT_W'(GAP_TIMEOUT);

            logic [GAP_CNT_W-1:0] cnt;

            // Saturates at GAP_TIMEOUT so a stalled count can never wrap back into range
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt <= '0;
                end else if (start) begin
                    cnt <= '0;
                end else if (run && (cnt != SAT)) begin
                    cnt <= cnt + 1'b1;
                end
            end

            assign expired = run && (cnt == LAST);
        end
    endgenerate

endmodule

// File: rtl/uart_cmd_wrapper.sv
// Pairs two received UART bytes into a 16-bit command and sends single-byte responses.
module uart_cmd_wrapper
    import uart_cmd_pkg::*;
#(
    parameter int unsigned GAP_TIMEOUT = 1_000_000,
    parameter int unsigned GAP_CNT_W   = (GAP_TIMEOUT > 0) ? $clog2(GAP_TIMEOUT + 1) : 1
) (
    input  logic                clk,
    input  logic                rst,
    uart_cmd_wrapper_if.slave   bus
);

    rx_state_t  rx_state;
    tx_state_t  tx_state;
    logic [7:0] high_byte;
    logic       gap_start;
    logic       gap_run;
    logic       gap_expired;

    assign gap_start = (rx_state == RX_IDLE) && bus.rx_rdy;
    assign gap_run   = (rx_state == RX_WAIT_LOW);

    assign bus.clr_rx_rdy = bus.rx_rdy && !rst;

    uart_cmd_gap_timer #(
        .GAP_TIMEOUT (GAP_TIMEOUT),
        .GAP_CNT_W   (GAP_CNT_W)
    ) u_gap_timer (
        .clk     (clk),
        .rst     (rst),
        .start   (gap_start),
        .run     (gap_run),
        .expired (gap_expired)
    );

    // Receive path; a completing low byte overrides clr_cmd_rdy in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state      <= RX_IDLE;
            high_byte     <= '0;
            bus.cmd       <= '0;
            bus.cmd_rdy   <= 1'b0;
            bus.frame_err <= 1'b0;
        end else begin
            bus.frame_err <= 1'b0;
            if (bus.clr_cmd_rdy) begin
                bus.cmd_rdy <= 1'b0;
            end
            case (rx_state)
                RX_IDLE: begin
                    if (bus.rx_rdy) begin
                        high_byte   <= bus.rx_data;
                        bus.cmd_rdy <= 1'b0;
                        rx_state    <= RX_WAIT_LOW;
                    end
                end
                RX_WAIT_LOW: begin
                    if (bus.rx_rdy) begin
                        bus.cmd     <= {high_byte, bus.rx_data};
                        bus.cmd_rdy <= 1'b1;
                        rx_state    <= RX_IDLE;
                    end else if (gap_expired) begin
                        bus.frame_err <= 1'b1;
                        rx_state      <= RX_IDLE;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // Transmit path; trmt and tx_busy are set on entry to TX_LOAD so they line up with it
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state      <= TX_IDLE;
            bus.tx_data   <= '0;
            bus.trmt      <= 1'b0;
            bus.tx_busy   <= 1'b0;
            bus.resp_sent <= 1'b0;
        end else begin
            bus.trmt <= 1'b0;
            case (tx_state)
                TX_IDLE: begin
                    if (bus.send_resp) begin
                        bus.tx_data   <= bus.resp;
                        bus.resp_sent <= 1'b0;
                        bus.trmt      <= 1'b1;
                        bus.tx_busy   <= 1'b1;
                        tx_state      <= TX_LOAD;
                    end
                end
                TX_LOAD: begin
                    tx_state <= TX_BUSY;
                end
                TX_BUSY: begin
                    if (bus.tx_done) begin
                        bus.resp_sent <= 1'b1;
                        bus.tx_busy   <= 1'b0;
                        tx_state      <= TX_IDLE;
                    end
                end
                default: begin
                    bus.tx_busy <= 1'b0;
                    tx_state    <= TX_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_cmd_wrapper.md
Name: uart_cmd_wrapper

Overview:
- Receive-side counterpart of the remote command sender; sits on the robot side, between the byte-level UART and the command processor.
- Assembles two received UART bytes (high byte first) into one 16-bit command with a cmd_rdy/clr_cmd_rdy handshake.
- Transmits single-byte responses (e.g. ACK 0xA5) back over the UART transmitter.
- Enforces an inter-byte gap timeout so a lost low byte cannot mis-pair with the next command.

Parameters:
- GAP_TIMEOUT, 1_000_000: clock cycles allowed between high and low byte before the partial command is discarded. 0 disables the timeout.
- GAP_CNT_W, $clog2(GAP_TIMEOUT+1): width of the gap counter (derived; do not override).

Ports:
- clk  in  1  single system clock, all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- rx_rdy  in  1  UART received byte valid.
- rx_data  in  8  UART received byte.
- clr_rx_rdy  out  1  one-cycle acknowledge of the received byte to the UART.
- trmt  out  1  one-cycle UART transmit strobe.
- tx_data  out  8  byte presented to the UART transmitter; registered.
- tx_done  in  1  UART transmit of current byte complete.
- cmd  out  16  assembled command {high, low}; registered.
- cmd_rdy  out  1  cmd valid, held until cleared.
- clr_cmd_rdy  in  1  consumer acknowledge of cmd.
- resp  in  8  response byte to send.
- send_resp  in  1  request to transmit resp.
- resp_sent  out  1  response transmit finished; held.
- tx_busy  out  1  response transmit in progress.
- frame_err  out  1  one-cycle pulse when a partial command is discarded on timeout.

Behaviour:
- Reset values (synchronous, rst=1 at posedge): cmd=0, cmd_rdy=0, resp_sent=0, tx_data=0, trmt=0, tx_busy=0, frame_err=0, clr_rx_rdy=0. Both FSMs return to idle. Reset mid-transfer drops any staged high byte and any pending transmit; trmt is not reissued.
- RX FSM states: RX_IDLE, RX_WAIT_LOW.
  - RX_IDLE & rx_rdy: capture rx_data into the high staging register, clear cmd_rdy, go to RX_WAIT_LOW.
  - RX_WAIT_LOW & rx_rdy: cmd <= {staged_high, rx_data}, cmd_rdy <= 1, go to RX_IDLE.
  - clr_rx_rdy is combinational, = rx_rdy in either state, so every byte is acknowledged in the cycle it is seen.
  - Latency: low byte rx_rdy at cycle N gives cmd/cmd_rdy valid at N+1.
  - cmd changes only on low-byte completion. It stays stable while only a high byte is staged; only cmd_rdy drops.
- cmd_rdy clears on clr_cmd_rdy or on capture of a new high byte. If a command completes in the same cycle as clr_cmd_rdy, set wins and cmd_rdy=1.
- Gap timer:
  - Loads 0 on entry to RX_WAIT_LOW and increments each cycle in RX_WAIT_LOW.
  - At count == GAP_TIMEOUT-1 with no rx_rdy: return to RX_IDLE, pulse frame_err for 1 cycle, leave cmd and cmd_rdy unchanged.
  - rx_rdy in the same cycle as expiry: the byte is taken as the low byte and frame_err is not asserted.
  - Counter saturates and never wraps.
- TX FSM states: TX_IDLE, TX_LOAD, TX_BUSY.
  - TX_IDLE & send_resp (cycle N): tx_data <= resp, resp_sent <= 0, go to TX_LOAD.
  - TX_LOAD: trmt=1 for exactly one cycle (N+1), go to TX_BUSY.
  - TX_BUSY & tx_done: resp_sent <= 1 (visible next cycle), go to TX_IDLE.
  - tx_busy=1 in TX_LOAD and TX_BUSY.
  - send_resp while busy is ignored, with no queuing. send_resp in the same cycle as tx_done (state TX_BUSY) is also ignored.
  - tx_data is held stable from TX_LOAD until the next accepted send_resp.
- RX and TX paths are independent; a command may be received while a response is transmitting.

Decomposition:
- Package uart_cmd_pkg:
  - rx_state_t {RX_IDLE, RX_WAIT_LOW}
  - tx_state_t {TX_IDLE, TX_LOAD, TX_BUSY}
  - localparams RESP_ACK=8'hA5, RESP_NAK=8'h5A
- One sub-module, uart_cmd_gap_timer: clk, rst, start, run → expired; parameterised by GAP_TIMEOUT, with a GAP_TIMEOUT=0 tie-off that keeps expired at 0.

Test Plan:
- Two bytes: rx_data 0x29 then 0x33, each rx_rdy one cycle, 20 cycles apart → clr_rx_rdy pulses on both; cmd=0x2933 and cmd_rdy=1 one cycle after the second byte, held until clr_cmd_rdy.
- Handshake collision: cmd_rdy=1, then a new command 0x4100 completes in the same cycle as clr_cmd_rdy → cmd=0x4100, cmd_rdy=1. High byte 0x41 arriving alone → cmd_rdy drops, cmd keeps the old value.
- Timeout: GAP_TIMEOUT=50. Byte 0x12, then 60 idle cycles, then 0x34, 0x56 → frame_err pulses once at cycle 50 after 0x12; final cmd=0x3456; 0x12 is never paired.
- Timeout edge: GAP_TIMEOUT=50, low byte rx_rdy exactly in the expiry cycle → accepted, frame_err=0.
- Response: send_resp with resp=0xA5 → tx_data=0xA5 and trmt pulse the next cycle; a second send_resp with 0x5A while busy is ignored; tx_done → resp_sent=1 next cycle; tx_data stays 0xA5.
- Reset mid-command: rst after the high byte, then bytes 0x0F, 0xF0 → cmd=0x0FF0, no frame_err, all outputs 0 during reset.
